// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Glyphs are stored in active-low g..a form: a 0 bit lights that segment.
package seg_scan_pkg;

    localparam int DEFAULT_REFRESH_CNT = 50000;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;
    localparam logic [6:0] BLANK   = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to 7-segment glyph decoder (active-low g..a).
// Latency: combinational.
// Backpressure: none.
//
// Ports: nibble - value to show; hex_mode - allow A-F (else 10-15 blank);
//        blank - force all segments off; glyph - active-low g..a.
module seg7_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = BLANK;
        if (!blank && (hex_mode || nibble <= 4'd9)) begin
            case (nibble)
                4'h0: glyph = GLYPH_0;
                4'h1: glyph = GLYPH_1;
                4'h2: glyph = GLYPH_2;
                4'h3: glyph = GLYPH_3;
                4'h4: glyph = GLYPH_4;
                4'h5: glyph = GLYPH_5;
                4'h6: glyph = GLYPH_6;
                4'h7: glyph = GLYPH_7;
                4'h8: glyph = GLYPH_8;
                4'h9: glyph = GLYPH_9;
                4'hA: glyph = GLYPH_A;
                4'hB: glyph = GLYPH_B;
                4'hC: glyph = GLYPH_C;
                4'hD: glyph = GLYPH_D;
                4'hE: glyph = GLYPH_E;
                default: glyph = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan driver with shadow load, LZ blanking, dp mask and PWM dimming.
// Latency: sel/seg/digit_tick registered; a load shows on seg from the capturing edge onward.
// Backpressure: none; load is a fire-and-forget strobe, the scan free-runs.
//
// Ports: clk, rst_n (async active-low); din/dp_mask/load - shadow register inputs;
//        hex_mode, blank_lz, duty - live display controls; sel - digit select
//        (DIGITS-1-index); seg - {dp,g..a} per ACTIVE_LOW_SEG; digit_tick - scan advance pulse.
// Optional: define SEG_SCAN_BLINK_EN to add blink_mask and a 256-scan blink phase.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SEL_W          = 3,
    parameter int REFRESH_CNT    = DEFAULT_REFRESH_CNT,
    parameter int DUTY_W         = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [DUTY_W-1:0]     duty,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [SEL_W-1:0]      sel,
    output logic [7:0]            seg,
    output logic                  digit_tick
);

    localparam int               CNT_W    = $clog2(REFRESH_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
    localparam logic [7:0]       SEG_OFF  = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]    slot_cnt;
    logic                slot_end;
    logic [SEL_W-1:0]    idx;
    logic [SEL_W-1:0]    idx_nx;
    logic [DUTY_W-1:0]   pwm_phase;
    logic [4*DIGITS-1:0] shad_din;
    logic [4*DIGITS-1:0] shad_din_nx;
    logic [DIGITS-1:0]   shad_dp;
    logic [DIGITS-1:0]   shad_dp_nx;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                lz_blank;
    logic                pwm_on;
    logic                dig_off;
    logic [6:0]          glyph;
    logic [7:0]          seg_al;
    logic [7:0]          seg_nx;

    assign slot_end = (slot_cnt == CNT_LAST);
    assign idx_nx   = !slot_end         ? idx :
                      (idx == IDX_LAST) ? '0  : idx + 1'b1;
    assign sel      = IDX_LAST - idx;

    // seg is registered from next-state values (index and shadow) so it
    // changes on the same edge as sel, and a load on a wrap edge is not lost
    // for the first cycle of the new digit.
    assign shad_din_nx = load ? din     : shad_din;
    assign shad_dp_nx  = load ? dp_mask : shad_dp;
    assign cur_nib     = shad_din_nx[4*idx_nx +: 4];
    assign cur_dp      = shad_dp_nx[idx_nx];

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lz_blank = blank_lz && (idx_nx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) >= idx_nx && shad_din_nx[4*i +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
    end

    seg7_decoder u_dec (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .blank    (lz_blank),
        .glyph    (glyph)
    );

    assign pwm_on = (pwm_phase < duty) || (&duty);

`ifdef SEG_SCAN_BLINK_EN
    logic [7:0] scan_cnt;
    logic       scan_wrap;
    logic       blink_off;
    logic       blink_off_nx;

    assign scan_wrap    = slot_end && (idx == IDX_LAST);
    assign blink_off_nx = (scan_wrap && scan_cnt == 8'hFF) ? ~blink_off : blink_off;
    assign dig_off      = blink_off_nx && blink_mask[idx_nx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= 8'h00;
            blink_off <= 1'b0;
        end else begin
            if (scan_wrap) begin
                scan_cnt <= scan_cnt + 8'h01;
            end
            blink_off <= blink_off_nx;
        end
    end
`else
    assign dig_off = 1'b0;
`endif

    // Built active-low, then flipped once for active-high boards.
    assign seg_al = (!pwm_on || dig_off) ? 8'hFF : {~cur_dp, glyph};
    assign seg_nx = ACTIVE_LOW_SEG ? seg_al : ~seg_al;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt   <= '0;
            digit_tick <= 1'b0;
            idx        <= '0;
            pwm_phase  <= '0;
            shad_din   <= '0;
            shad_dp    <= '0;
            seg        <= SEG_OFF;
        end else begin
            slot_cnt   <= slot_end ? '0 : slot_cnt + 1'b1;
            digit_tick <= slot_end;
            idx        <= idx_nx;
            pwm_phase  <= pwm_phase + 1'b1;
            shad_din   <= shad_din_nx;
            shad_dp    <= shad_dp_nx;
            seg        <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIGITS=6, REFRESH_CNT=32, DUTY_W=4, active-low).
// Expected seg values are queued when display state is driven and popped at each digit_tick.
// Covers reset, scan order, hex/BCD, dp, leading-zero blanking, PWM, load timing, optional blink.
module tb_seg_scan_ctrl;

    localparam int DIGITS  = 6;
    localparam int REFRESH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] din;
    logic [5:0]  dp_mask;
    logic        load;
    logic        hex_mode;
    logic        blank_lz;
    logic [3:0]  duty;
`ifdef SEG_SCAN_BLINK_EN
    logic [5:0]  blink_mask;
`endif
    logic [2:0]  sel;
    logic [7:0]  seg;
    logic        digit_tick;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_idx = 0;
    int          m_wraps = 0;
    int          lit;
    logic [23:0] sh_din = '0;
    logic [5:0]  sh_dp = '0;
    logic [7:0]  sb_q[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS         (DIGITS),
        .SEL_W          (3),
        .REFRESH_CNT    (REFRESH),
        .DUTY_W         (4),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .dp_mask    (dp_mask),
        .load       (load),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .duty       (duty),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .sel        (sel),
        .seg        (seg),
        .digit_tick (digit_tick)
    );

    // Reference glyph bytes {dp=off, g..a}, active-low.
    function automatic logic [7:0] glyph_ref(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        logic [3:0] nib;
        logic       blank;
        logic [7:0] r;
        nib   = sh_din[i*4 +: 4];
        blank = blank_lz && (i > 0);
        for (int j = i; j < DIGITS; j++) begin
            if (sh_din[j*4 +: 4] != 4'h0) blank = 1'b0;
        end
        if (blank || (!hex_mode && nib > 4'd9)) r = 8'hFF;
        else                                    r = glyph_ref(nib);
        if (sh_dp[i]) r[7] = 1'b0;
        if (duty == 4'h0) r = 8'hFF;
        return r;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic apply(input logic [23:0] d, input logic [5:0] dp, input logic hx,
                         input logic lz, input logic [3:0] du, input bit ld);
        @(posedge clk); #1;
        din = d; dp_mask = dp; hex_mode = hx; blank_lz = lz; duty = du; load = ld;
        if (ld) begin
            sh_din = d;
            sh_dp  = dp;
        end
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic push_scan(input int n);
        for (int k = 1; k <= n; k++) sb_q.push_back(exp_seg((m_idx + k) % DIGITS));
    endtask

    // Waits (bounded) for the next digit_tick, then checks sel and optionally seg.
    task automatic next_slot(input bit per, input bit do_seg);
        int         w;
        logic [7:0] e;
        w = 1;
        @(negedge clk);
        while (!digit_tick && w < 4*REFRESH) begin
            @(negedge clk);
            w++;
        end
        if (!digit_tick) begin
            chk_val("tick_timeout", 32'(digit_tick), 32'd1);
            return;
        end
        if (m_idx == DIGITS-1) begin
            m_idx = 0;
            m_wraps++;
        end else begin
            m_idx++;
        end
        if (per) chk_val("slot_period", w, REFRESH);
        chk_val("sel", 32'(sel), DIGITS-1-m_idx);
        if (do_seg) begin
            if (sb_q.size() == 0) begin
                chk_val("sb_underflow", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                chk_val($sformatf("seg_d%0d", m_idx), 32'(seg), 32'(e));
            end
        end
    endtask

    task automatic run_scan(input int n);
        push_scan(n);
        for (int k = 0; k < n; k++) next_slot(1'b0, 1'b1);
    endtask

    task automatic count_lit(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (seg != 8'hFF) cnt++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; din = '0; dp_mask = '0; load = 1'b0;
        hex_mode = 1'b0; blank_lz = 1'b0; duty = 4'hF;
`ifdef SEG_SCAN_BLINK_EN
        blink_mask = '0;
`endif
        repeat (3) @(negedge clk);
        chk_val("rst_sel",  32'(sel),        32'(3'b101));
        chk_val("rst_seg",  32'(seg),        32'(8'hFF));
        chk_val("rst_tick", 32'(digit_tick), 32'd0);
        rst_n = 1'b1;

        // Scan order and wrap, plus slot period.
        apply(24'h123456, 6'h00, 1'b0, 1'b0, 4'hF, 1'b1);
        push_scan(7);
        next_slot(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) next_slot(1'b1, 1'b1);

        // Hex on/off and decimal point.
        apply(24'h00000A, 6'h00, 1'b1, 1'b0, 4'hF, 1'b1);
        run_scan(6);
        apply(24'h00000A, 6'h00, 1'b0, 1'b0, 4'hF, 1'b0);
        run_scan(6);
        apply(24'h123456, 6'b000100, 1'b0, 1'b0, 4'hF, 1'b1);
        run_scan(6);

        // Leading-zero blanking; blanked digit 5 keeps its dp.
        apply(24'h000120, 6'b100000, 1'b0, 1'b1, 4'hF, 1'b1);
        run_scan(6);
        apply(24'h000120, 6'b100000, 1'b0, 1'b0, 4'hF, 1'b0);
        run_scan(6);

        // Changing din without load leaves the display alone.
        apply(24'h999999, 6'b000000, 1'b0, 1'b0, 4'hF, 1'b0);
        run_scan(6);

        // Load pulsed on the slot-wrap edge shows on the very next digit.
        repeat (REFRESH-1) @(posedge clk);
        #1;
        din = 24'h654321; dp_mask = 6'h00; load = 1'b1;
        sh_din = 24'h654321; sh_dp = 6'h00;
        push_scan(6);
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 0; k < 6; k++) next_slot(1'b0, 1'b1);

        // Brightness: dark but still scanning, half duty, full on.
        apply(24'h123456, 6'h00, 1'b0, 1'b0, 4'h0, 1'b1);
        run_scan(6);
        count_lit(16, lit);
        chk_val("lit_duty0", lit, 0);
        next_slot(1'b0, 1'b0);
        apply(24'h123456, 6'h00, 1'b0, 1'b0, 4'h8, 1'b0);
        @(posedge clk);
        count_lit(16, lit);
        chk_val("lit_duty8", lit, 8);
        next_slot(1'b0, 1'b0);
        apply(24'h123456, 6'h00, 1'b0, 1'b0, 4'hF, 1'b0);
        @(posedge clk);
        count_lit(16, lit);
        chk_val("lit_dutyF", lit, 16);
        next_slot(1'b0, 1'b0);

`ifdef SEG_SCAN_BLINK_EN
        // Digit 0 goes dark (dp included) once 256 scans have wrapped.
        blink_mask = 6'b000001;
        while (!(m_wraps == 255 && m_idx == DIGITS-1)) next_slot(1'b0, 1'b0);
        sb_q.push_back(8'hFF);
        sb_q.push_back(exp_seg(1));
        next_slot(1'b0, 1'b1);
        next_slot(1'b0, 1'b1);
`endif

        // Asynchronous reset in the middle of a slot.
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_val("arst_sel",  32'(sel),        32'(3'b101));
        chk_val("arst_seg",  32'(seg),        32'(8'hFF));
        chk_val("arst_tick", 32'(digit_tick), 32'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
